layer_sequencer: RTL and testbench
==================================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter NUM_SPIKES, default 16: number of input spike channels.
REQ-002 Parameter LOG_TESTING_PERIOD, default 3: width of a spike-time field, excluding its enable bit.
REQ-003 Parameter TESTING_PERIOD, default 8: number of inference cycles per sample.
REQ-004 Parameter TIME_PERIOD, default 24 (TESTING_PERIOD+NUM_SPIKES): number of cycles per training sample.
REQ-005 Parameter LOG_TIME_PERIOD, default 5; parameter LOG_NEURONS_PER_LAYER, default 4.
REQ-006 Port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-007 Port rst_l, input, 1: asynchronous, active-low reset.
REQ-008 Port in_valid, input, 1: a sample is offered.
REQ-009 Port in_ready, output, 1: the sequencer accepts the offered sample.
REQ-010 Port in_spike_times, input, NUM_SPIKES x (LOG_TESTING_PERIOD+1): spike times of the offered sample; MSB of each field is an active-low enable.
REQ-011 Port in_train, input, 1: the offered sample is a training sample.
REQ-012 Port time_val, output, LOG_TIME_PERIOD+1: time step driven to the layer.
REQ-013 Port training, output, 1: training mode driven to the layer.
REQ-014 Port spike_times, output, same width as in_spike_times: latched sample driven to the layer.
REQ-015 Port layer_spike_time, input, LOG_TESTING_PERIOD+1: layer output spike time; MSB set means no spike.
REQ-016 Port layer_winner, input, LOG_NEURONS_PER_LAYER+1: layer winning neuron; all-ones means none.
REQ-017 Port res_valid, output, 1: a result is held.
REQ-018 Port res_ready, input, 1: the consumer takes the result.
REQ-019 Port res_spike_time and port res_winner, outputs, same widths as the layer inputs: the captured result.
REQ-020 Port busy, output, 1: state is not IDLE.
REQ-021 Port sample_count, output, 16: number of completed samples.

Function
REQ-022 States SHALL be IDLE, TEST and LEARN, held in a registered FSM.
REQ-023 in_ready SHALL be 1 only in IDLE with res_valid=0.
REQ-024 On in_valid&in_ready, the sequencer SHALL latch in_spike_times into spike_times and in_train into training, and move to TEST with time_val=0 on the next cycle.
REQ-025 In TEST and LEARN, time_val SHALL increment by 1 every cycle.
REQ-026 In IDLE, time_val SHALL be 0 and training SHALL be 0; spike_times SHALL hold its last value.
REQ-027 In TEST with time_val=TESTING_PERIOD-1, the sequencer SHALL register layer_spike_time into res_spike_time and layer_winner into res_winner at that clock edge, and set res_valid=1 from the next cycle.
REQ-028 At that same edge, the FSM SHALL go to LEARN when training=1 and to IDLE otherwise; time_val SHALL go to TESTING_PERIOD or to 0 respectively.
REQ-029 In LEARN with time_val=TIME_PERIOD-1, the FSM SHALL go to IDLE, with time_val=0 and training=0 on the next cycle.
REQ-030 sample_count SHALL increment by 1, wrapping from 0xFFFF to 0, on each transition into IDLE from TEST or LEARN.
REQ-031 res_valid SHALL clear on a cycle with res_valid&res_ready; res_spike_time and res_winner SHALL remain stable while res_valid=1.
REQ-032 A result handshake SHALL be allowed during LEARN; the next sample SHALL NOT be accepted until the FSM is in IDLE and res_valid=0.
REQ-033 If res_ready is asserted in the same cycle in which res_valid is set, the result SHALL NOT be taken in that cycle.
REQ-034 in_valid SHALL be ignored outside IDLE; in_spike_times and in_train SHALL NOT affect any output unless accepted.
REQ-035 Each non-training sample SHALL take TESTING_PERIOD busy cycles; each training sample SHALL take TIME_PERIOD busy cycles.

Reset
REQ-036 While rst_l=0, the sequencer SHALL hold: state IDLE, time_val=0, training=0, spike_times all ones (all channels disabled), res_valid=0, res_spike_time all ones, res_winner all ones, sample_count=0, busy=0.
REQ-037 An assertion of rst_l during TEST or LEARN SHALL abort the sample immediately, and no result SHALL be produced.

Verification
REQ-038 Inference: accept in_train=0 while res_ready=1 -> time_val runs 0..7, res_valid rises the cycle after time_val=7 with the layer values sampled at time_val=7, and busy lasts 8 cycles.
REQ-039 Training: accept in_train=1 -> time_val runs 0..23, training=1 for 24 cycles, res_valid rises after time_val=7, and sample_count increments once after time_val=23.
REQ-040 Backpressure: hold res_ready=0 after a sample completes -> in_ready=0 and the result is stable; raise res_ready -> res_valid clears, and in_ready=1 on the following cycle.
REQ-041 in_valid held high for three samples -> the samples are accepted back-to-back with one IDLE cycle between them, and sample_count=3.
REQ-042 Reset at time_val=12 of a training sample -> all outputs take their REQ-036 values asynchronously, and no result is produced.
REQ-043 sample_count preloaded to 0xFFFF by forcing -> after one more sample, sample_count=0.

Source files
------------

// File: rtl/layer_sequencer_if.sv
// Sample-in / result-out handshake and layer drive bundle for layer_sequencer.
// The slave modport is the sequencer side and the master modport is the environment side.
`timescale 1ns/1ps
interface layer_sequencer_if #(
    parameter int NUM_SPIKES            = 16,
    parameter int LOG_TESTING_PERIOD    = 3,
    parameter int LOG_TIME_PERIOD       = 5,
    parameter int LOG_NEURONS_PER_LAYER = 4
);
    logic                                            in_valid;
    logic                                            in_ready;
    logic [NUM_SPIKES*(LOG_TESTING_PERIOD+1)-1:0]    in_spike_times;
    logic                                            in_train;
    logic [LOG_TIME_PERIOD:0]                        time_val;
    logic                                            training;
    logic [NUM_SPIKES*(LOG_TESTING_PERIOD+1)-1:0]    spike_times;
    logic [LOG_TESTING_PERIOD:0]                     layer_spike_time;
    logic [LOG_NEURONS_PER_LAYER:0]                  layer_winner;
    logic                                            res_valid;
    logic                                            res_ready;
    logic [LOG_TESTING_PERIOD:0]                     res_spike_time;
    logic [LOG_NEURONS_PER_LAYER:0]                  res_winner;
    logic                                            busy;
    logic [15:0]                                     sample_count;

    modport slave (
        input  in_valid, in_spike_times, in_train, layer_spike_time, layer_winner, res_ready,
        output in_ready, time_val, training, spike_times, res_valid, res_spike_time,
               res_winner, busy, sample_count
    );

    modport master (
        output in_valid, in_spike_times, in_train, layer_spike_time, layer_winner, res_ready,
        input  in_ready, time_val, training, spike_times, res_valid, res_spike_time,
               res_winner, busy, sample_count
    );
endinterface

// File: rtl/layer_sequencer.sv
// Steps one spiking layer through a sample: TESTING_PERIOD inference cycles, then
// optional learning cycles up to TIME_PERIOD, capturing the layer result at end of test.
`timescale 1ns/1ps
module layer_sequencer #(
    parameter int NUM_SPIKES            = 16,
    parameter int LOG_TESTING_PERIOD    = 3,
    parameter int TESTING_PERIOD        = 8,
    parameter int TIME_PERIOD           = 24,
    parameter int LOG_TIME_PERIOD       = 5,
    parameter int LOG_NEURONS_PER_LAYER = 4
) (
    input  logic             clk,
    input  logic             rst_l,
    layer_sequencer_if.slave bus
);
    localparam int SW = NUM_SPIKES * (LOG_TESTING_PERIOD + 1);
    localparam int LW = LOG_TESTING_PERIOD + 1;
    localparam int WW = LOG_NEURONS_PER_LAYER + 1;
    localparam int TW = LOG_TIME_PERIOD + 1;

    localparam logic [TW-1:0] TEST_LAST   = TW'(TESTING_PERIOD - 1);
    localparam logic [TW-1:0] LEARN_FIRST = TW'(TESTING_PERIOD);
    localparam logic [TW-1:0] LEARN_LAST  = TW'(TIME_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, TEST, LEARN} state_t;

    state_t          state;
    logic [TW-1:0]   time_step;
    logic            train_mode;
    logic [SW-1:0]   spikes;
    logic            res_vld;
    logic [LW-1:0]   res_st;
    logic [WW-1:0]   res_win;
    logic [15:0]     sample_cnt;
    logic            accept;

    // A held result blocks the next sample so it can never be overwritten.
    assign accept = bus.in_valid && (state == IDLE) && !res_vld;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= IDLE;
            time_step  <= '0;
            train_mode <= 1'b0;
            spikes     <= '1;
            res_vld    <= 1'b0;
            res_st     <= '1;
            res_win    <= '1;
            sample_cnt <= '0;
        end else begin
            if (res_vld && bus.res_ready) begin
                res_vld <= 1'b0;
            end
            case (state)
                IDLE: begin
                    time_step  <= '0;
                    train_mode <= 1'b0;
                    if (accept) begin
                        state      <= TEST;
                        spikes     <= bus.in_spike_times;
                        train_mode <= bus.in_train;
                    end
                end
                TEST: begin
                    time_step <= time_step + 1'b1;
                    if (time_step == TEST_LAST) begin
                        res_st  <= bus.layer_spike_time;
                        res_win <= bus.layer_winner;
                        res_vld <= 1'b1;
                        if (train_mode) begin
                            state     <= LEARN;
                            time_step <= LEARN_FIRST;
                        end else begin
                            state      <= IDLE;
                            time_step  <= '0;
                            train_mode <= 1'b0;
                            sample_cnt <= sample_cnt + 16'd1;
                        end
                    end
                end
                LEARN: begin
                    time_step <= time_step + 1'b1;
                    if (time_step == LEARN_LAST) begin
                        state      <= IDLE;
                        time_step  <= '0;
                        train_mode <= 1'b0;
                        sample_cnt <= sample_cnt + 16'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    time_step <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready       = (state == IDLE) && !res_vld;
    assign bus.time_val       = time_step;
    assign bus.training       = train_mode;
    assign bus.spike_times    = spikes;
    assign bus.res_valid      = res_vld;
    assign bus.res_spike_time = res_st;
    assign bus.res_winner     = res_win;
    assign bus.busy           = (state != IDLE);
    assign bus.sample_count   = sample_cnt;
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: table of whole samples plus hand-written
// backpressure, back-to-back, mid-sample reset and counter-wrap sequences.
`timescale 1ns/1ps
module tb_layer_sequencer;
    logic clk = 1'b0;
    logic rst_l = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [15:0] exp_cnt = 16'd0;

    layer_sequencer_if bus ();

    layer_sequencer dut (
        .clk  (clk),
        .rst_l(rst_l),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [63:0] st;
        logic        train;
        int          base;
        logic        rr;
        logic [3:0]  exp_ls;
        logic [4:0]  exp_lw;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Layer values change every cycle so a capture at the wrong step is visible.
    function automatic logic [3:0] lay_st(input int base, input int step);
        return 4'((base + step) & 15);
    endfunction

    function automatic logic [4:0] lay_win(input int base, input int step);
        return 5'((base * 3 + step * 5) & 31);
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_time_val"}, 64'(bus.time_val), 64'd0);
        chk({tag, "_training"}, 64'(bus.training), 64'd0);
        chk({tag, "_spike_times"}, bus.spike_times, 64'hFFFF_FFFF_FFFF_FFFF);
        chk({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        chk({tag, "_res_spike_time"}, 64'(bus.res_spike_time), 64'hF);
        chk({tag, "_res_winner"}, 64'(bus.res_winner), 64'h1F);
        chk({tag, "_sample_count"}, 64'(bus.sample_count), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic run_sample(input logic [63:0] st, input logic train, input int base,
                              input logic rr, input logic [3:0] els, input logic [4:0] elw);
        bit   ok;
        int   len;
        logic exp_rv;
        bus.res_ready = rr;
        wait_ready(ok);
        if (!ok) return;
        bus.in_valid       = 1'b1;
        bus.in_spike_times = st;
        bus.in_train       = train;
        @(negedge clk);
        bus.in_valid       = 1'b0;
        bus.in_spike_times = {$urandom, $urandom};
        bus.in_train       = ~train;
        len = train ? 24 : 8;
        for (int step = 0; step < len; step++) begin
            exp_rv = (step <= 7) ? 1'b0 : (step == 8) ? 1'b1 : !rr;
            chk("time_val", 64'(bus.time_val), 64'(step));
            chk("training", 64'(bus.training), 64'(train));
            chk("busy", 64'(bus.busy), 64'd1);
            chk("spike_times", bus.spike_times, st);
            chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
            chk("res_valid_run", 64'(bus.res_valid), 64'(exp_rv));
            if (step == 8) begin
                chk("res_spike_time", 64'(bus.res_spike_time), 64'(els));
                chk("res_winner", 64'(bus.res_winner), 64'(elw));
            end
            bus.layer_spike_time = lay_st(base, step);
            bus.layer_winner     = lay_win(base, step);
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 16'd1;
        chk("end_busy", 64'(bus.busy), 64'd0);
        chk("end_time_val", 64'(bus.time_val), 64'd0);
        chk("end_training", 64'(bus.training), 64'd0);
        chk("end_spike_times", bus.spike_times, st);
        chk("end_sample_count", 64'(bus.sample_count), 64'(exp_cnt));
        if (!train) begin
            chk("end_res_valid", 64'(bus.res_valid), 64'd1);
            chk("end_res_spike_time", 64'(bus.res_spike_time), 64'(els));
            chk("end_res_winner", 64'(bus.res_winner), 64'(elw));
            chk("end_in_ready", 64'(bus.in_ready), 64'd0);
            if (rr) begin
                @(negedge clk);
                chk("taken_res_valid", 64'(bus.res_valid), 64'd0);
                chk("taken_in_ready", 64'(bus.in_ready), 64'd1);
            end
        end else begin
            chk("end_res_valid", 64'(bus.res_valid), 64'(!rr));
            chk("end_in_ready", 64'(bus.in_ready), 64'(rr));
        end
    endtask

    // Result held under backpressure: stable, blocks new samples, then released.
    task automatic backpressure(input logic [63:0] st, input logic [3:0] els, input logic [4:0] elw);
        bus.in_valid       = 1'b1;
        bus.in_train       = 1'b1;
        bus.in_spike_times = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            bus.layer_spike_time = 4'($urandom);
            bus.layer_winner     = 5'($urandom);
            @(negedge clk);
            chk("bp_res_valid", 64'(bus.res_valid), 64'd1);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_busy", 64'(bus.busy), 64'd0);
            chk("bp_res_spike_time", 64'(bus.res_spike_time), 64'(els));
            chk("bp_res_winner", 64'(bus.res_winner), 64'(elw));
            chk("bp_spike_times", bus.spike_times, st);
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_res_valid", 64'(bus.res_valid), 64'd0);
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        bit   ok;
        int   runs;
        int   run_len;
        int   gap;
        bit   prev;
        bit   done;

        vecs[0] = '{st: 64'h0123_4567_89AB_CDEF, train: 1'b0, base: 3,  rr: 1'b1, exp_ls: 4'hA, exp_lw: 5'h0C};
        vecs[1] = '{st: 64'hFFFF_0000_8888_7777, train: 1'b1, base: 9,  rr: 1'b1, exp_ls: 4'h0, exp_lw: 5'h1E};
        vecs[2] = '{st: 64'h7654_3210_FEDC_BA98, train: 1'b0, base: 14, rr: 1'b0, exp_ls: 4'h5, exp_lw: 5'h0D};
        vecs[3] = '{st: 64'h0F0F_F0F0_1234_8765, train: 1'b1, base: 20, rr: 1'b0, exp_ls: 4'hB, exp_lw: 5'h1F};

        bus.in_valid         = 1'b1;
        bus.in_spike_times   = 64'h0;
        bus.in_train         = 1'b1;
        bus.layer_spike_time = 4'h0;
        bus.layer_winner     = 5'h0;
        bus.res_ready        = 1'b0;
        rst_l                = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        bus.in_valid = 1'b0;
        rst_l        = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);

        for (int v = 0; v < 4; v++) begin
            run_sample(vecs[v].st, vecs[v].train, vecs[v].base, vecs[v].rr,
                       vecs[v].exp_ls, vecs[v].exp_lw);
            if (!vecs[v].rr) backpressure(vecs[v].st, vecs[v].exp_ls, vecs[v].exp_lw);
        end

        // Reset in the middle of a training sample.
        bus.res_ready = 1'b0;
        wait_ready(ok);
        bus.in_valid       = 1'b1;
        bus.in_train       = 1'b1;
        bus.in_spike_times = 64'h1111_2222_3333_4444;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_time_val", 64'(bus.time_val), 64'd12);
        rst_l = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        rst_l = 1'b1;
        exp_cnt = 16'd0;
        @(negedge clk);
        chk("abort_after_busy", 64'(bus.busy), 64'd0);
        chk("abort_after_res_valid", 64'(bus.res_valid), 64'd0);

        // Three training samples with in_valid held high.
        bus.res_ready      = 1'b1;
        bus.in_train       = 1'b1;
        bus.in_spike_times = 64'hABCD_EF01_2345_6789;
        bus.in_valid       = 1'b1;
        runs = 0; run_len = 0; gap = 0; prev = 1'b0; done = 1'b0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (bus.busy) begin
                if (!prev) begin
                    runs++;
                    if (runs > 1) chk("b2b_gap", 64'(gap), 64'd1);
                    if (runs == 3) bus.in_valid = 1'b0;
                end
                run_len++;
            end else begin
                if (prev) begin
                    chk("b2b_len", 64'(run_len), 64'd24);
                    run_len = 0;
                    gap = 0;
                    if (runs == 3) done = 1'b1;
                end
                gap++;
            end
            prev = bus.busy;
            if (done) break;
        end
        bus.in_valid = 1'b0;
        chk("b2b_done", 64'(done), 64'd1);
        chk("b2b_sample_count", 64'(bus.sample_count), 64'd3);
        exp_cnt = 16'd3;

        // Counter wrap from 0xFFFF.
        @(negedge clk);
        force dut.sample_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.sample_cnt;
        @(negedge clk);
        chk("wrap_preload", 64'(bus.sample_count), 64'hFFFF);
        exp_cnt = 16'hFFFF;
        run_sample(64'h8765_4321_0FED_CBA9, 1'b0, 5, 1'b1, 4'hC, 5'h12);
        chk("wrap_zero", 64'(bus.sample_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
